// File: rtl/lc3_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_fetch_pkg
// Description : Shared definitions for the LC3 prefetching fetch unit.
//               Control-flow opcodes, the fetch FSM state encoding and the
//               PC-offset sign-extension helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_fetch_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  // Results are 32 bits wide so callers can truncate to any ADDR_W <= 32.
  function automatic logic [31:0] sext9(input logic [8:0] v);
    return {{23{v[8]}}, v};
  endfunction

  function automatic logic [31:0] sext11(input logic [10:0] v);
    return {{21{v[10]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : DEPTH-entry synchronous FIFO of {pc, instr} pairs.
//               flush empties the queue and overrides push/pop.
// Ports       : clk, rst (async, active-high)
//               push/push_pc/push_instr - write a new entry
//               pop                     - remove the head entry
//               flush                   - discard all entries
//               head_pc/head_instr      - head entry (undefined when empty)
//               empty, count            - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [ADDR_W-1:0]      push_pc,
  input  logic [15:0]            push_instr,
  input  logic                   pop,
  input  logic                   flush,
  output logic [ADDR_W-1:0]      head_pc,
  output logic [15:0]            head_instr,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 16;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign pop_ok  = pop & ~empty;
  // A push into a full queue is accepted when the head leaves the same cycle.
  assign push_ok = push & ((count_q != CNT_W'(DEPTH)) | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= {push_pc, push_instr};
  end

  assign {head_pc, head_instr} = mem_q[rd_ptr_q];
  assign count                 = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_pf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pf
// Description : LC3 prefetching fetch unit. Issues sequential reads to a
//               1-cycle-latency instruction memory, queues returned words with
//               their PC and hands them to decode over valid/ready. Resolved
//               BR/JSR/JMP redirect the PC, flush the queue and drop the
//               returning read.
// Config      : FETCH_BYPASS_EN - present a return directly to decode when
//               the queue is empty (saves one cycle of latency).
// Ports       : clk, rst (async, active-high), fetch_start
//               mem_req/mem_addr/wea_out/mem_rdata - instruction memory
//               pc                                 - next fetch address
//               instr_out/instr_pc/instr_valid/instr_ready - decode handshake
//               resolve_valid/resolve_pc/opCode_in/offset_in/reg_in/
//               br_nzp/result_nzp                  - resolved control flow
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pf #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              wea_out,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              resolve_valid,
  input  logic [ADDR_W-1:0] resolve_pc,
  input  logic [3:0]        opCode_in,
  input  logic [10:0]       offset_in,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp
);

  import lc3_fetch_pkg::*;

  fetch_state_e            state_q, state_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic                    ret_valid_q, ret_valid_d;   // read returning this cycle
  logic [ADDR_W-1:0]       ret_pc_q, ret_pc_d;

  logic                    redirect_taken;
  logic [ADDR_W-1:0]       redirect_target;
  logic                    credit_ok;
  logic                    ret_live;
  logic                    q_push, q_pop, q_empty;
  logic [ADDR_W-1:0]       q_pc;
  logic [15:0]             q_instr;
  logic [$clog2(DEPTH):0]  q_count;

  // ---------------- redirect decode ----------------
  always_comb begin
    redirect_taken  = 1'b0;
    redirect_target = reg_in;
    if (resolve_valid) begin
      case (opCode_in)
        OP_BR: begin
          redirect_taken  = |(br_nzp & result_nzp);
          redirect_target = resolve_pc + ADDR_W'(1) + ADDR_W'(sext9(offset_in[8:0]));
        end
        OP_JSR: begin
          redirect_taken  = 1'b1;
          redirect_target = resolve_pc + ADDR_W'(1) + ADDR_W'(sext11(offset_in));
        end
        OP_JMP: begin
          redirect_taken  = 1'b1;
          redirect_target = reg_in;
        end
        default: ;
      endcase
    end
  end

  // The returning read counts against the queue so it always has a slot.
  assign credit_ok = (int'(q_count) + int'(ret_valid_q)) < DEPTH;
  assign ret_live  = ret_valid_q & ~redirect_taken;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (redirect_taken && ret_valid_q) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = fetch_start ? ST_RUN : ST_IDLE;
        ST_RUN:   state_d = fetch_start ? ST_RUN : ST_IDLE;
        ST_FLUSH: state_d = fetch_start ? ST_RUN : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mem_req = (state_q != ST_IDLE) & fetch_start & credit_ok & ~redirect_taken;
  end

  // ---------------- PC and return tracking ----------------
  always_comb begin
    pc_d        = pc_q;
    ret_valid_d = mem_req;
    ret_pc_d    = pc_q;
    if (redirect_taken) pc_d = redirect_target;
    else if (mem_req)   pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      ret_valid_q <= 1'b0;
      ret_pc_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      ret_valid_q <= ret_valid_d;
      ret_pc_q    <= ret_pc_d;
    end
  end

  assign pc       = pc_q;
  assign mem_addr = pc_q;
  assign wea_out  = 1'b0;

  // ---------------- queue and decode-side outputs ----------------
  always_comb begin
    q_push      = ret_live;
    q_pop       = ~q_empty & instr_ready & ~redirect_taken;
    instr_valid = ~q_empty;
    instr_out   = q_empty ? 16'h0000 : q_instr;
    instr_pc    = q_empty ? '0 : q_pc;
`ifdef FETCH_BYPASS_EN
    if (q_empty && ret_live) begin
      instr_valid = 1'b1;
      instr_out   = mem_rdata;
      instr_pc    = ret_pc_q;
      q_push      = ~instr_ready;   // consumed directly, skip the queue
    end
`endif
  end

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_pc    (ret_pc_q),
    .push_instr (mem_rdata),
    .pop        (q_pop),
    .flush      (redirect_taken),
    .head_pc    (q_pc),
    .head_instr (q_instr),
    .empty      (q_empty),
    .count      (q_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_pf.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pf
// Description : Self-checking bench for fetch_pf (DEPTH=4, RESET_PC=3000).
//               Directed table, latency/reset sequences and a randomized run
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pf;

  localparam int          ADDR_W = 16;
  localparam int          DEPTH  = 4;
  localparam logic [15:0] RPC    = 16'h3000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst, fetch_start, mem_req, wea_out, instr_valid, instr_ready;
  logic [15:0] mem_addr, pc, instr_out, instr_pc, mem_rdata;
  logic        resolve_valid;
  logic [15:0] resolve_pc, reg_in;
  logic [3:0]  opCode_in;
  logic [10:0] offset_in;
  logic [2:0]  br_nzp, result_nzp;

  fetch_pf #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start),
    .mem_req(mem_req), .mem_addr(mem_addr), .wea_out(wea_out), .mem_rdata(mem_rdata),
    .pc(pc), .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .opCode_in(opCode_in), .offset_in(offset_in), .reg_in(reg_in),
    .br_nzp(br_nzp), .result_nzp(result_nzp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word at address a is a ^ 5A5A, one cycle latency.
  always @(posedge clk) mem_rdata <= mem_req ? (mem_addr ^ 16'h5A5A) : 16'($urandom);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [15:0] pc; logic [15:0] data; } ent_t;
  ent_t        mq[$];
  logic [15:0] m_pc, m_ret_pc;
  bit          m_act, m_infl;

  task automatic model_reset();
    mq.delete();
    m_pc = RPC; m_act = 1'b0; m_infl = 1'b0; m_ret_pc = '0;
  endtask

  task automatic redir(output bit tk, output logic [15:0] tg);
    int off;
    tk = 1'b0; tg = '0;
    if (resolve_valid) begin
      case (opCode_in)
        4'b0000: begin
          tk  = (br_nzp & result_nzp) != 3'b000;
          off = int'($signed(offset_in[8:0]));
          tg  = 16'(int'(resolve_pc) + 1 + off);
        end
        4'b0100: begin
          tk  = 1'b1;
          off = int'($signed(offset_in));
          tg  = 16'(int'(resolve_pc) + 1 + off);
        end
        4'b1100: begin tk = 1'b1; tg = reg_in; end
        default: ;
      endcase
    end
  endtask

  // One clock: compare at the falling edge, advance the model, return at posedge+1.
  task automatic cycle(input bit tchk, input bit ereq, input logic [15:0] eaddr);
    bit          tk, byp, e_val, e_req;
    logic [15:0] tg;
    ent_t        head;
    @(negedge clk);
    redir(tk, tg);
    byp   = BYP && (mq.size() == 0) && m_infl && !tk;
    head  = '0;
    if (byp) head = '{m_ret_pc, m_ret_pc ^ 16'h5A5A};
    else if (mq.size() > 0) head = mq[0];
    e_val = byp || (mq.size() > 0);
    e_req = m_act && fetch_start && (mq.size() + int'(m_infl) < DEPTH) && !tk;
    if (tchk) begin
      chk("tbl_req", mem_req, ereq);
      chk("tbl_addr", mem_addr, eaddr);
    end
    chk("req", mem_req, e_req);
    chk("addr", mem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("wea", wea_out, 0);
    chk("valid", instr_valid, e_val);
    if (e_val) begin
      chk("ipc", instr_pc, head.pc);
      chk("iout", instr_out, head.data);
    end
    if (tk) mq.delete();
    else begin
      if (e_val && instr_ready && !byp) void'(mq.pop_front());
      if (m_infl && !(byp && instr_ready)) mq.push_back('{m_ret_pc, m_ret_pc ^ 16'h5A5A});
    end
    m_act  = fetch_start || (tk && m_infl);
    m_infl = e_req;
    if (e_req) m_ret_pc = m_pc;
    if (tk) m_pc = tg;
    else if (e_req) m_pc = m_pc + 16'd1;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    fetch_start = 0; instr_ready = 0; resolve_valid = 0; opCode_in = 4'h0;
    resolve_pc = '0; offset_in = '0; reg_in = '0; br_nzp = '0; result_nzp = '0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_pc"}, pc, RPC);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit fs, rdy, rv; logic [3:0] op; logic [15:0] rpc; logic [10:0] off;
    logic [15:0] rg; logic [2:0] bn, rn; bit ereq; logic [15:0] eaddr;
  } vec_t;
  vec_t tbl[21];

  function automatic vec_t mk(bit fs, bit rdy, bit rv, logic [3:0] op, logic [15:0] rpc,
                              logic [10:0] off, logic [15:0] rg, logic [2:0] bn,
                              logic [2:0] rn, bit ereq, logic [15:0] eaddr);
    vec_t v;
    v.fs = fs; v.rdy = rdy; v.rv = rv; v.op = op; v.rpc = rpc; v.off = off;
    v.rg = rg; v.bn = bn; v.rn = rn; v.ereq = ereq; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    fetch_start = v.fs; instr_ready = v.rdy; resolve_valid = v.rv; opCode_in = v.op;
    resolve_pc = v.rpc; offset_in = v.off; reg_in = v.rg; br_nzp = v.bn; result_nzp = v.rn;
  endtask

  initial begin
    // backpressure fill, drain, BR taken, JMP, BR not taken, stop, JSR while stopped
    tbl[0]  = mk(1,0,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,0,16'h3000);
    tbl[1]  = mk(1,0,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,1,16'h3000);
    tbl[2]  = mk(1,0,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,1,16'h3001);
    tbl[3]  = mk(1,0,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,1,16'h3002);
    tbl[4]  = mk(1,0,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,1,16'h3003);
    tbl[5]  = mk(1,0,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,0,16'h3004);
    tbl[6]  = mk(1,0,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,0,16'h3004);
    tbl[7]  = mk(1,1,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,0,16'h3004);
    tbl[8]  = mk(1,1,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,1,16'h3004);
    tbl[9]  = mk(1,1,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,1,16'h3005);
    tbl[10] = mk(1,1,1,4'h0,16'h3002,11'h005,16'h0,3'b010,3'b010,0,16'h3006);
    tbl[11] = mk(1,1,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,1,16'h3008);
    tbl[12] = mk(1,1,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,1,16'h3009);
    tbl[13] = mk(1,1,1,4'hC,16'h0,11'h0,16'h4000,3'b000,3'b000,0,16'h300A);
    tbl[14] = mk(1,1,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,1,16'h4000);
    tbl[15] = mk(1,1,1,4'h0,16'h4000,11'h007,16'h0,3'b100,3'b001,1,16'h4001);
    tbl[16] = mk(1,1,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,1,16'h4002);
    tbl[17] = mk(0,1,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,0,16'h4003);
    tbl[18] = mk(0,1,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,0,16'h4003);
    tbl[19] = mk(0,1,1,4'h4,16'h4010,11'h7F0,16'h0,3'b000,3'b000,0,16'h4003);
    tbl[20] = mk(0,1,0,4'h0,16'h0,11'h0,16'h0,3'b000,3'b000,0,16'h4001);

    // ---- reset with no start ----
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, RPC);
    chk("rst_pc", pc, RPC);
    chk("rst_wea", wea_out, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_iout", instr_out, 0);
    chk("rst_ipc", instr_pc, 0);
    @(posedge clk); #1;
    repeat (3) cycle(0, 0, '0);

    // ---- directed table ----
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i]);
      cycle(1, tbl[i].ereq, tbl[i].eaddr);
    end

    // ---- first-word latency ----
    idle_inputs();
    do_reset("rst1");
    fetch_start = 1; instr_ready = 1;
    cycle(0, 0, '0);            // IDLE -> RUN
    cycle(0, 0, '0);            // first request, 3000
    chk("lat_n1_valid", instr_valid, BYP);
    cycle(0, 0, '0);
    chk("lat_n2_valid", instr_valid, 1);
    chk("lat_n2_ipc", instr_pc, BYP ? 16'h3001 : 16'h3000);
    repeat (6) cycle(0, 0, '0);

    // ---- reset in mid-stream ----
    do_reset("rst2");
    chk("rst2_after_valid", instr_valid, 0);
    idle_inputs();
    cycle(0, 0, '0);

    // ---- randomized run ----
    for (int n = 0; n < 2000; n++) begin
      fetch_start = ($urandom_range(0, 15) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      resolve_valid = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: opCode_in = 4'b0000;
        1: opCode_in = 4'b0100;
        2: opCode_in = 4'b1100;
        default: opCode_in = 4'($urandom);
      endcase
      resolve_pc = 16'($urandom);
      offset_in  = 11'($urandom);
      reg_in     = 16'($urandom);
      br_nzp     = 3'($urandom);
      result_nzp = 3'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset("rrst");
      else cycle(0, 0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_pf.md
# fetch_pf

Parametrised LC3 prefetching fetch unit: issues sequential instruction reads to a 1-cycle-latency instruction memory, buffers returned words with their PC in a DEPTH-entry queue, and hands them to decode over a valid/ready handshake. Resolved control flow redirects the PC, flushes the queue and squashes the in-flight read. It sits between instruction memory and decode, and replaces the single-word `fetch` block.

## Interface
- ADDR_W, 16, PC/memory address width
- DEPTH, 4, prefetch queue entries (power of 2, ≥2)
- RESET_PC, 0, PC value after reset
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_start  in  1  fetch enable; low means no new memory requests
- mem_req  out  1  read request, memory always accepts
- mem_addr  out  ADDR_W  read address, equals pc
- wea_out  out  1  memory write enable, constant 0
- mem_rdata  in  16  read data, valid the cycle after mem_req
- pc  out  ADDR_W  next fetch address
- instr_out  out  16  queue head instruction
- instr_pc  out  ADDR_W  address of instr_out
- instr_valid  out  1  head valid
- instr_ready  in  1  decode accepts head
- resolve_valid  in  1  control-flow instruction resolved this cycle
- resolve_pc  in  ADDR_W  address of the resolved instruction
- opCode_in  in  4  opcode of the resolved instruction
- offset_in  in  11  PC offset field
- reg_in  in  ADDR_W  base register value (JMP/RET)
- br_nzp  in  3  BR condition field
- result_nzp  in  3  current condition codes

## Operation
- Reset: pc=RESET_PC, mem_req=0, wea_out=0, instr_valid=0, instr_out=0, instr_pc=0, queue empty, state IDLE.
- States: IDLE (fetch_start=0), RUN, FLUSH. IDLE→RUN when fetch_start=1. RUN→IDLE when fetch_start=0. Any state→FLUSH on a taken redirect while a read is in flight. FLUSH lasts one cycle, then returns to RUN or IDLE according to fetch_start.
- Credit: mem_req = fetch_start & (count + inflight < DEPTH); mem_req is 0 in IDLE. Each request does pc <= pc+1, modulo 2^ADDR_W.
- Return: the cycle after a request, {pc_of_request, mem_rdata} is pushed into the queue, unless squashed.
- Pop: when instr_valid & instr_ready, the head is removed.
- Redirect, evaluated only when resolve_valid=1:
  - BR (0000): taken if |(br_nzp & result_nzp); target = resolve_pc+1+sext(offset_in[8:0]).
  - JSR (0100): always taken; target = resolve_pc+1+sext(offset_in[10:0]).
  - JMP (1100): always taken; target = reg_in.
  - Any other opcode, or BR not taken: no effect.
- A taken redirect does the following:
  - Queue cleared.
  - pc <= target.
  - No request issued in the redirect cycle.
  - The in-flight read, if any, is dropped when it returns (FLUSH).
- Simultaneous events:
  - Redirect + pop: redirect wins and the queue ends empty.
  - Redirect + return: the return is dropped.
  - Push + pop on a full queue: legal; the count is unchanged.
- fetch_start falling mid-stream: the in-flight read still completes and is queued; the queue contents are kept.
- Redirect with fetch_start=0: pc is updated and the queue flushed; no request is issued.
- rst mid-operation: immediate return to the reset values; the in-flight read is discarded.

## Timing
- Request in cycle N → push at the end of N+1 → instr_valid in N+2 (N+1 with bypass).
- Steady state, instr_ready=1: one instruction per cycle.
- Redirect in cycle R → first target request in R+1 → target instruction valid in R+3 (R+2 with bypass).
- Queue full and no pop: mem_req stays 0; pc is held.

## Configuration
- FETCH_BYPASS_EN defined: when the queue is empty and a non-squashed return arrives, instr_out/instr_pc/instr_valid are driven combinationally from the return in that cycle.
  - If instr_ready=1, the word is not written into the queue.
- FETCH_BYPASS_EN undefined: every return is written into the queue; outputs come only from the queue head.

## Structure
- Package lc3_fetch_pkg: OP_BR=4'b0000, OP_JSR=4'b0100, OP_JMP=4'b1100; state encoding IDLE/RUN/FLUSH; sext9/sext11 functions.
- Sub-module fetch_queue: synchronous DEPTH-entry FIFO of {ADDR_W pc, 16 instr} with push, pop, flush and count outputs.
- fetch_pf holds the pc register, the FSM, the credit logic and the redirect logic.

## Test plan
- No start: rst=1 for 5 cycles, fetch_start=0, then release → mem_addr=0, mem_req=0, wea_out=0, pc=0, instr_valid=0.
- Sequential: RESET_PC=16'h3000, fetch_start=1, instr_ready=1 → mem_addr 3000, 3001, …; instr_pc=3000 appears 2 cycles after the first request, then one per cycle.
- Backpressure: instr_ready=0 → exactly 4 requests (DEPTH=4), mem_req then 0, pc=3004. Raising instr_ready resumes requests with no loss or duplication.
- BR taken:
  - Stimulus: resolve_pc=3002, br_nzp=010, result_nzp=010, offset_in=11'h005.
  - Response: queue flushed, next mem_addr=3008; the in-flight word is never presented.
- BR not taken / JMP:
  - br_nzp=100, result_nzp=001 → stream is undisturbed.
  - JMP with reg_in=4000 → next mem_addr=4000.
- Bypass: with FETCH_BYPASS_EN, empty queue, instr_ready=1 → instr_valid in the cycle after the first request. Without the macro → one cycle later.
